// File: rtl/pll_clk_mgr_if.sv
// Configuration request/response bundle between a host and pll_clk_mgr.
interface pll_clk_mgr_if #(
    parameter int DIV_W = 10
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_ratio;
    logic [DIV_W-1:0] cfg_duty;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_ratio, cfg_duty, cfg_phase,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_ratio, cfg_duty, cfg_phase,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/pll_clk_mgr.sv
// PLL lock qualifier, downstream reset sequencer and NUM_CH runtime-programmable
// clock-enable / divided-waveform generators, all on the single PLL clock.
module pll_clk_ch #(
    parameter int DIV_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             upd,
    input  logic [DIV_W-1:0] upd_ratio,
    input  logic [DIV_W-1:0] upd_duty,
    input  logic [DIV_W-1:0] upd_phase,
    output logic             at_end,
    output logic             ce,
    output logic             clk_div
);
    logic [DIV_W-1:0] ratio_q, ratio_d, duty_q, duty_d, phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] re, re_n, pe_n;
    logic             ce_q, ce_d, div_q, div_d;

    always_comb begin
        re      = (ratio_q == '0) ? DIV_W'(1) : ratio_q;
        at_end  = (cnt_q == re - DIV_W'(1));
        ratio_d = upd ? upd_ratio : ratio_q;
        duty_d  = upd ? upd_duty  : duty_q;
        phase_d = upd ? upd_phase : phase_q;
        re_n    = (ratio_d == '0) ? DIV_W'(1) : ratio_d;
        pe_n    = (phase_d < re_n) ? phase_d : '0;
        // Outputs use the current settings; an update only takes effect from the reload.
        ce_d    = go & (cnt_q == '0);
        div_d   = go & (cnt_q < duty_q);
        if (!go || upd)
            cnt_d = (pe_n == '0) ? '0 : re_n - pe_n;
        else if (at_end)
            cnt_d = '0;
        else
            cnt_d = cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio_q <= DIV_W'(2);
            duty_q  <= DIV_W'(1);
            phase_q <= '0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            ratio_q <= ratio_d;
            duty_q  <= duty_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
            div_q   <= div_d;
        end
    end

    assign ce      = ce_q;
    assign clk_div = div_q;
endmodule

module pll_clk_mgr #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 10,
    parameter int LOCK_CYCLES = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    pll_clk_mgr_if.slave      cfg,
    output logic              rst_out_n,
    output logic              lock_lost,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_div
);
    localparam int CW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {S_WAIT, S_STABLE, S_RUN} state_t;

    typedef struct packed {
        logic [2:0]       ch;
        logic [DIV_W-1:0] ratio;
        logic [DIV_W-1:0] duty;
        logic [DIV_W-1:0] phase;
    } cfg_req_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          lcnt_q, lcnt_d;
    logic                   rst_out_n_q, rst_out_n_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   pend_q, pend_d;
    logic                   err_q, err_d;
    cfg_req_t               req_q, req_d;
    logic                   go, accept, ch_ok;
    logic [NUM_CH-1:0]      upd, at_end;

    assign lock_s = sync_q[SYNC_STAGES-1];
    assign go     = (state_q == S_RUN);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pll_lock};
        state_d = state_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            S_WAIT: begin
                lcnt_d = '0;
                if (lock_s) state_d = S_STABLE;
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    lcnt_d  = '0;
                end else if (lcnt_q == CW'(LOCK_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    lcnt_d = lcnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    lcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_WAIT;
                lcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        rst_out_n_d = go;
        // Flag the RUN exit on the same cycle the downstream reset asserts.
        lock_lost_d = lock_lost_q | (rst_out_n_q & ~go);
        accept      = cfg.cfg_valid & ~pend_q;
        ch_ok       = ({1'b0, cfg.cfg_ch} < 4'(NUM_CH));
        err_d       = accept & ~ch_ok;
        pend_d      = pend_q;
        req_d       = req_q;
        if (|upd) pend_d = 1'b0;
        if (accept && ch_ok) begin
            pend_d = 1'b1;
            req_d  = '{ch: cfg.cfg_ch, ratio: cfg.cfg_ratio,
                       duty: cfg.cfg_duty, phase: cfg.cfg_phase};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= S_WAIT;
            lcnt_q      <= '0;
            rst_out_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            rst_out_n_q <= rst_out_n_d;
            lock_lost_q <= lock_lost_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            req_q       <= req_d;
        end
    end

    // A pending update lands on the last count of its period, or at once when idle.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign upd[i] = pend_q & (req_q.ch == 3'(i)) & (~go | at_end[i]);

        pll_clk_ch #(.DIV_W(DIV_W)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .go        (go),
            .upd       (upd[i]),
            .upd_ratio (req_q.ratio),
            .upd_duty  (req_q.duty),
            .upd_phase (req_q.phase),
            .at_end    (at_end[i]),
            .ce        (ce[i]),
            .clk_div   (clk_div[i])
        );
    end

    assign cfg.cfg_ready = ~pend_q;
    assign cfg.cfg_err   = err_q;
    assign rst_out_n     = rst_out_n_q;
    assign lock_lost     = lock_lost_q;
endmodule

// File: tb/tb_pll_clk_mgr.sv
// Directed + randomized bench for pll_clk_mgr against a cycle-level reference model
// built from lock-history windows and modular channel arithmetic.
module tb_pll_clk_mgr;
    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 10;
    localparam int LOCK_CYCLES = 16;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst_n, pll_lock, rst_out_n, lock_lost;
    logic [NUM_CH-1:0] ce, clk_div;

    pll_clk_mgr_if #(.DIV_W(DIV_W)) cfg_if ();

    pll_clk_mgr #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .cfg       (cfg_if),
        .rst_out_n (rst_out_n),
        .lock_lost (lock_lost),
        .ce        (ce),
        .clk_div   (clk_div)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int                m_R [NUM_CH];
    int                m_D [NUM_CH];
    int                m_P [NUM_CH];
    int                m_t [NUM_CH];
    logic [NUM_CH-1:0] m_ce, m_div;
    bit                m_pend, m_err, m_run, m_rst, m_lost;
    int                m_pch, m_pr, m_pd, m_pp, run_len;
    int                hist[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_R[c] = 2; m_D[c] = 1; m_P[c] = 0; m_t[c] = 0;
        end
        m_ce = '0; m_div = '0;
        m_pend = 0; m_err = 0; m_run = 0; m_rst = 0; m_lost = 0;
        run_len = 0;
        hist.delete();
        repeat (SYNC_STAGES) hist.push_back(0);
    endtask

    // RUN holds once the raw lock, seen SYNC_STAGES edges ago, has been high for
    // LOCK_CYCLES+1 consecutive samples; channel position = (Re-Pe+t) mod Re.
    task automatic model_edge();
        bit go, pend_old, ap;
        int re, pe, pos;
        if (!rst_n) begin
            m_reset();
            return;
        end
        go       = m_run;
        pend_old = m_pend;
        for (int c = 0; c < NUM_CH; c++) begin
            re = (m_R[c] == 0) ? 1 : m_R[c];
            pe = (m_P[c] < re) ? m_P[c] : 0;
            ap = pend_old && (m_pch == c);
            if (go) begin
                pos      = (re - pe + m_t[c]) % re;
                m_ce[c]  = (pos == 0);
                m_div[c] = (pos < m_D[c]);
                ap       = ap && (pos == re - 1);
                m_t[c]   = (m_t[c] + 1) % re;
            end else begin
                m_ce[c]  = 1'b0;
                m_div[c] = 1'b0;
                m_t[c]   = 0;
            end
            if (ap) begin
                m_R[c] = m_pr; m_D[c] = m_pd; m_P[c] = m_pp; m_t[c] = 0;
                m_pend = 0;
            end
        end
        m_err = 0;
        if (cfg_if.cfg_valid && !pend_old) begin
            if (int'(cfg_if.cfg_ch) < NUM_CH) begin
                m_pend = 1;
                m_pch  = int'(cfg_if.cfg_ch);
                m_pr   = int'(cfg_if.cfg_ratio);
                m_pd   = int'(cfg_if.cfg_duty);
                m_pp   = int'(cfg_if.cfg_phase);
            end else begin
                m_err = 1;
            end
        end
        run_len = pll_lock ? ((run_len < 100000) ? run_len + 1 : run_len) : 0;
        hist.push_back(run_len);
        if (hist.size() > SYNC_STAGES + 1) void'(hist.pop_front());
        m_run = (hist[0] >= LOCK_CYCLES + 1);
        if (m_rst && !go) m_lost = 1;
        m_rst = go;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("rst_out_n", rst_out_n, m_rst);
        chk("lock_lost", lock_lost, m_lost);
        chk("ce", ce, m_ce);
        chk("clk_div", clk_div, m_div);
        chk("cfg_ready", cfg_if.cfg_ready, !m_pend);
        chk("cfg_err", cfg_if.cfg_err, m_err);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_rst_out_n"}, rst_out_n, 0);
        chk({tag, "_lock_lost"}, lock_lost, 0);
        chk({tag, "_ce"}, ce, 0);
        chk({tag, "_clk_div"}, clk_div, 0);
        chk({tag, "_cfg_ready"}, cfg_if.cfg_ready, 1);
        chk({tag, "_cfg_err"}, cfg_if.cfg_err, 0);
    endtask

    task automatic send(int ch, int r, int d, int p);
        bit done = 0;
        bit acc;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'(ch);
        cfg_if.cfg_ratio = DIV_W'(r);
        cfg_if.cfg_duty  = DIV_W'(d);
        cfg_if.cfg_phase = DIV_W'(p);
        for (int k = 0; k < 64 && !done; k++) begin
            acc = !m_pend;
            step();
            if (acc) done = 1;
        end
        cfg_if.cfg_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_ready(int maxc);
        bit ok = 0;
        for (int k = 0; k < maxc; k++) begin
            if (cfg_if.cfg_ready === 1'b1) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) ok = (cfg_if.cfg_ready === 1'b1);
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_rst(bit val, int maxc, output int at);
        at = -1;
        for (int k = 0; k < maxc; k++) begin
            step();
            if (rst_out_n === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int at, g, f;
        rst_n            = 1'b1;
        pll_lock         = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_ratio = '0;
        cfg_if.cfg_duty  = '0;
        cfg_if.cfg_phase = '0;
        m_reset();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        repeat (3) step();
        rst_n = 1'b1;
        cyc   = 0;

        // Clean release: lock sampled high from cycle 10
        while (cyc < 9) step();
        pll_lock = 1'b1;
        wait_rst(1, 60, at);
        chk("release_cycle", at, 29);
        repeat (8) step();

        // Async reset with a request still pending
        send(2, 9, 4, 0);
        chk("pend_before_rst", cfg_if.cfg_ready, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        m_reset();
        pll_lock = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // One-cycle lock glitch during STABLE restarts qualification
        step();
        pll_lock = 1'b1;
        repeat (6) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        g = cyc + 1;
        wait_rst(1, 60, at);
        chk("glitch_release", at, g + SYNC_STAGES + LOCK_CYCLES + 1);
        chk("glitch_lost", lock_lost, 0);

        // Reconfigure ch1 in RUN: R=5 D=2 P=3 -> load 2, ce on index 3, div 11000
        repeat (3) step();
        send(1, 5, 2, 3);
        chk("ready_low_after_accept", cfg_if.cfg_ready, 0);
        wait_ready(10);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("r5_ce", ce[1], (k % 5) == 3);
            chk("r5_div", clk_div[1], ((k + 2) % 5) < 2);
        end

        // Boundaries
        send(2, 0, 1, 0);
        wait_ready(10);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("r0_ce_high", ce[2], 1);
        end
        send(3, 4, 7, 0);
        wait_ready(10);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("d_ge_r_div_high", clk_div[3], 1);
        end
        send(0, 4, 1, 9);
        wait_ready(10);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("p_ovf_ce", ce[0], (k % 4) == 0);
        end
        send(6, 3, 1, 1);
        chk("bad_ch_err", cfg_if.cfg_err, 1);
        chk("bad_ch_ready", cfg_if.cfg_ready, 1);
        step();
        chk("bad_ch_err_clr", cfg_if.cfg_err, 0);

        // Lock loss in RUN, then relock
        pll_lock = 1'b0;
        f = cyc + 1;
        wait_rst(0, 20, at);
        chk("loss_cycle", at, f + SYNC_STAGES + 1);
        chk("loss_ce", ce, 0);
        chk("loss_lost", lock_lost, 1);
        pll_lock = 1'b1;
        wait_rst(1, 60, at);
        chk("relock", rst_out_n, 1);
        chk("lost_sticky", lock_lost, 1);

        // Randomized reconfiguration and lock drops
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 5)) step();
            if ($urandom_range(0, 9) == 0) begin
                pll_lock = 1'b0;
                repeat ($urandom_range(1, 4)) step();
                pll_lock = 1'b1;
            end else begin
                send($urandom_range(0, NUM_CH + 1), $urandom_range(0, 9),
                     $urandom_range(0, 10), $urandom_range(0, 10));
            end
        end
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pll_clk_mgr.md
# pll_clk_mgr

Parametrised clock-management block that sits directly after the PLL wrapper. It qualifies the PLL lock and sequences a synchronous reset. From the PLL output clock it derives NUM_CH clock-enable pulses and divided square waves. Each channel's ratio, duty and phase can be reprogrammed at runtime. Downstream logic (core, UART, timers) runs on the single PLL clock and uses `ce[i]` instead of additional PLL outputs. This adds runtime reconfiguration and lock-loss handling that a static PLL wrapper lacks.

## Interface
Parameters:
- `NUM_CH`, 4, number of derived channels (1..8)
- `DIV_W`, 10, width of ratio/duty/phase fields
- `LOCK_CYCLES`, 1024, consecutive synchronised-lock cycles required before release (≥1)
- `SYNC_STAGES`, 2, synchroniser depth for `pll_lock` (≥2)

Ports:
- `clk`  in  1  PLL output clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pll_lock`  in  1  raw PLL lock, asynchronous to `clk`
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  configuration accepted when `cfg_valid & cfg_ready`
- `cfg_ch`  in  3  target channel index
- `cfg_ratio`  in  DIV_W  period in `clk` cycles
- `cfg_duty`  in  DIV_W  high cycles per period
- `cfg_phase`  in  DIV_W  delay of first `ce` after channel start
- `cfg_err`  out  1  one-cycle pulse: accepted request had `cfg_ch >= NUM_CH`
- `rst_out_n`  out  1  synchronous active-low reset for downstream logic
- `lock_lost`  out  1  sticky; set on lock loss while in RUN; cleared only by `rst_n`
- `ce`  out  NUM_CH  one-cycle enable per channel period
- `clk_div`  out  NUM_CH  registered divided waveform (logic signal, not a clock net)

## Operation
- `pll_lock` passes through a SYNC_STAGES flop chain; `lock_s` is the synchroniser output.
- FSM states:
  - WAIT: counter cleared while `lock_s=0`; go to STABLE when `lock_s=1`.
  - STABLE: count increments each cycle `lock_s=1`; if `lock_s=0`, return to WAIT with count cleared; when count reaches LOCK_CYCLES-1, go to RUN.
  - RUN: if `lock_s=0`, go to WAIT and set `lock_lost`.
- `rst_out_n` is a registered version of (state==RUN).
- Per-channel state: `ratio` R, `duty` D, `phase` P, and counter `cnt` of width DIV_W.
- Effective ratio is `Re = max(R, 1)`. Effective phase is P if `P < Re`, else 0.
- Channel start:
  - Occurs on the cycle `rst_out_n` rises, and after any reconfiguration of that channel.
  - `cnt` loads `(Re - P) mod Re`.
- While running:
  - `cnt` counts 0..Re-1 and wraps.
  - `ce=1` when `cnt==0`.
  - `clk_div=1` when `cnt < D`. D=0 gives constant low; D≥Re gives constant high.
  - Re=1 gives `ce` constantly high.
- Outside RUN: `ce=0`, `clk_div=0`, and counters are held at their load value.
- Configuration handshake:
  - One pending-request register. `cfg_ready = !pending`.
  - A valid channel's pending value is applied on the cycle that channel's `cnt==Re-1`, or immediately if not in RUN. `cnt` reloads in the same cycle, so the new period starts on the next cycle with no glitch.
  - Applying the update clears `pending`.
  - A request with an invalid `cfg_ch` is dropped in its acceptance cycle: `cfg_err` is pulsed the next cycle and `pending` is never set.
- Reset values (after `rst_n` low): every channel R=2, D=1, P=0; state WAIT; `rst_out_n=0`; `lock_lost=0`; `ce=0`; `clk_div=0`; `cfg_ready=1`; `cfg_err=0`.

## Timing
- `pll_lock` rise to `rst_out_n` rise = SYNC_STAGES + LOCK_CYCLES + 1 cycles, if lock stays high throughout.
- The first `ce` of a P=0 channel is in the same cycle `rst_out_n` rises. With P=k<Re, it comes k cycles later.
- `pll_lock` fall (in RUN) to `rst_out_n=0`, `ce` cleared, and `lock_lost=1` = SYNC_STAGES + 1 cycles.
- `ce`/`clk_div` are registered, with no combinational path from any input.
- Worst-case config latency = Re of the target channel plus 1 cycle. `cfg_ready` goes low the cycle after acceptance.
- Simultaneous lock loss and pending apply: the apply still occurs (RUN exits), and the channel restarts from its new values on the next RUN entry.
- Async `rst_n` mid-operation: all outputs go to their reset values immediately, and any pending request is discarded.

## Test plan
- Lock release: `pll_lock` high at cycle 10, LOCK_CYCLES=16, SYNC_STAGES=2 -> `rst_out_n` rises at cycle 29. Ch0 `ce` then appears every 2 cycles, and `clk_div` is high 1 of every 2 cycles.
- Glitchy lock: `pll_lock` drops for 1 cycle during STABLE -> count restarts, release is delayed by the full LOCK_CYCLES, and `lock_lost` stays 0.
- Reconfigure in RUN: ch1 set to R=5, D=2, P=3 mid-period -> the old period completes, there are no short pulses, and the new `ce` period is 5 with `clk_div` pattern 11000. `cfg_ready` is low until the apply.
- Boundaries: R=0 -> `ce` constantly high. D=7 with R=4 -> `clk_div` constantly high. P=9 with R=4 -> treated as P=0. `cfg_ch=6` with NUM_CH=4 -> `cfg_err` pulse and no channel changes.
- Lock loss in RUN: `pll_lock` falls -> 3 cycles later `rst_out_n=0`, all `ce=0`, and `lock_lost=1`. After relock, `lock_lost` is still 1.
- `rst_n` asserted with a pending request -> `cfg_ready=1`, channel values return to R=2/D=1/P=0, and all outputs take their reset values.
